cotm32_mem_arbiter: RTL and testbench
=====================================

// Module: cotm32_mem_arbiter
// PURPOSE
//  Shares one single-port memory bus between IFU instruction fetch and LSU load/store.
//  Each port uses a req/gnt/rvalid handshake. One transaction is outstanding at a time.
//  Sits between the IFU/LSU and the unified memory. A watchdog returns an error if memory stalls.
// PARAMETERS
//  XLEN            32   data and address width
//  TIMEOUT_CYCLES  16   max cycles in REQ+RESP before error response; 0 disables the watchdog
// PORTS
//  clk           in   1       clock, rising edge
//  rst           in   1       asynchronous, active-high reset
//  ifu_req_i     in   1       fetch request; held with ifu_addr_i stable until ifu_gnt_o
//  ifu_addr_i    in   XLEN    fetch address
//  ifu_gnt_o     out  1       fetch accepted (1-cycle pulse)
//  ifu_rvalid_o  out  1       fetch response valid (1-cycle pulse)
//  ifu_rdata_o   out  XLEN    fetched instruction; 0 when ifu_rvalid_o=0
//  ifu_err_o     out  1       qualifies ifu_rvalid_o: watchdog timeout
//  lsu_req_i     in   1       data request; payload held stable until lsu_gnt_o
//  lsu_we_i      in   1       1=store, 0=load
//  lsu_be_i      in   XLEN/8  byte enables
//  lsu_addr_i    in   XLEN    data address
//  lsu_wdata_i   in   XLEN    store data
//  lsu_gnt_o     out  1       data request accepted (1-cycle pulse)
//  lsu_rvalid_o  out  1       data response valid (loads and stores)
//  lsu_rdata_o   out  XLEN    load data; 0 when lsu_rvalid_o=0
//  lsu_err_o     out  1       qualifies lsu_rvalid_o: watchdog timeout
//  mem_req_o     out  1       memory request; held until mem_gnt_i
//  mem_we_o / mem_be_o / mem_addr_o / mem_wdata_o   out   registered payload
//  mem_gnt_i     in   1       memory accepted request
//  mem_rvalid_i  in   1       memory response valid
//  mem_rdata_i   in   XLEN    memory read data
// BEHAVIOUR
//  - Reset: state=IDLE, owner=IFU, counter=0. All *_o registers are 0, including mem_req_o and mem_be_o.
//    Any in-flight transaction is dropped with no response. A late mem_rvalid_i is ignored.
//  - FSM states are IDLE, REQ and RESP.
//  - IDLE: if any req, pick an owner and assert its gnt_o combinationally in that cycle.
//    On the edge, capture the owner's payload into mem_* and go to REQ.
//    IFU payload: we=0, be=all-ones.
//  - REQ: mem_req_o=1 and the payload is stable. On mem_gnt_i, drop mem_req_o and go to RESP.
//  - RESP: on mem_rvalid_i, the owner sees rvalid_o=1 and rdata_o=mem_rdata_i combinationally, then go to IDLE.
//    A mem_rvalid_i seen outside RESP is ignored.
//  - Latency: the minimum is 2 cycles from gnt_o to rvalid_o (gnt at c0, mem_gnt at c1, rvalid at c2).
//    Back-to-back accesses have 1 IDLE bubble between them.
//  - Priority (default): LSU beats IFU when both request in the same IDLE cycle.
//    The loser keeps its req asserted and is not granted that cycle.
//  - Watchdog: the counter clears on entry to REQ and increments each cycle in REQ or RESP.
//    If it reaches TIMEOUT_CYCLES-1 without completion, the owner gets rvalid_o=1, err_o=1 and rdata_o=0.
//    mem_req_o then drops and the FSM goes to IDLE.
//    If completion and timeout happen in the same cycle, completion wins and err_o=0.
//  - No alignment checking is done; the LSU owns misalignment traps.
// CONFIGURATION
//  - COTM32_ARB_RR_EN defined: round-robin on contention.
//    The last-granted owner loses the next tie. The last-owner register resets to LSU, so IFU wins the first tie.
//  - Not defined: fixed LSU priority as above. The last-owner register is not built.
// TESTING
//  1. Single IFU fetch of 0x100, mem_gnt_i immediate, rvalid the next cycle with 0x00000013
//     -> ifu_gnt_o at c0, mem_req_o at c1, ifu_rvalid_o=1 and ifu_rdata_o=0x13 at c2, ifu_err_o=0.
//  2. LSU store: addr 0x2000, be=4'b0011, wdata 0xDEADBEEF, mem_gnt_i delayed 3 cycles
//     -> mem_req_o held 4 cycles with payload stable, then lsu_rvalid_o pulse.
//  3. IFU and LSU request in the same cycle
//     -> default: lsu_gnt_o first, ifu_gnt_o after LSU rvalid plus 1 bubble.
//     -> RR_EN: the IFU is granted first, then the LSU. Repeated ties then alternate.
//  4. Memory never asserts mem_rvalid_i, TIMEOUT_CYCLES=16
//     -> 16 cycles after gnt, owner rvalid_o=1, err_o=1, rdata_o=0, FSM in IDLE.
//     -> A later stray mem_rvalid_i produces no response.
//  5. rst asserted while in RESP
//     -> all outputs 0 immediately. No rvalid_o after release.
//     -> A new request after release is granted normally.
//  6. TIMEOUT_CYCLES=0 with a 100-cycle memory stall -> no error; the response is delivered at cycle 100.

Source files
------------

// File: rtl/cotm32_mem_arbiter.sv
// cotm32_mem_arbiter
//   Shares one single-port memory bus between the IFU (instruction fetch)
//   and the LSU (load/store). One transaction is outstanding at a time:
//   IDLE grants a requester combinationally, REQ presents the registered
//   payload to memory until mem_gnt_i, and RESP waits for mem_rvalid_i.
//   A watchdog answers with an error response when memory stalls for too long.
//
// Parameters
//   XLEN            data / address width
//   TIMEOUT_CYCLES  cycles allowed in REQ+RESP before an error response;
//                   0 disables the watchdog
//
// Configuration macro
//   COTM32_ARB_RR_EN  round-robin on contention (last granted owner loses the
//                     next tie). Undefined: the LSU always wins a tie.
//
// Ports
//   clk, rst                      clock (rising edge), async active-high reset
//   ifu_req_i/ifu_addr_i          fetch request and address
//   ifu_gnt_o                     fetch accepted (combinational pulse in IDLE)
//   ifu_rvalid_o/rdata_o/err_o    fetch response, data, timeout flag
//   lsu_req_i/we_i/be_i/addr_i/wdata_i  data request payload
//   lsu_gnt_o                     data request accepted
//   lsu_rvalid_o/rdata_o/err_o    data response, load data, timeout flag
//   mem_req_o + mem_we/be/addr/wdata_o  registered memory request
//   mem_gnt_i/mem_rvalid_i/mem_rdata_i  memory handshake and read data
module cotm32_mem_arbiter #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_i,
  input  logic [XLEN-1:0]   ifu_addr_i,
  output logic              ifu_gnt_o,
  output logic              ifu_rvalid_o,
  output logic [XLEN-1:0]   ifu_rdata_o,
  output logic              ifu_err_o,
  input  logic              lsu_req_i,
  input  logic              lsu_we_i,
  input  logic [XLEN/8-1:0] lsu_be_i,
  input  logic [XLEN-1:0]   lsu_addr_i,
  input  logic [XLEN-1:0]   lsu_wdata_i,
  output logic              lsu_gnt_o,
  output logic              lsu_rvalid_o,
  output logic [XLEN-1:0]   lsu_rdata_o,
  output logic              lsu_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [XLEN/8-1:0] mem_be_o,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i
);

  localparam int BE_W  = XLEN / 8;
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  state_t           state_q, state_d;
  logic             owner_lsu_q, owner_lsu_d;   // 0 = IFU, 1 = LSU
  logic [CNT_W-1:0] wd_cnt_q;
  logic             pick_lsu;
  logic             grant;
  logic             done;
  logic             wd_hit;

  // ---- arbitration (IDLE, combinational) ----
`ifdef COTM32_ARB_RR_EN
  logic last_lsu_q;

  // On a tie the owner granted most recently yields.
  always_comb pick_lsu = lsu_req_i && (!ifu_req_i || !last_lsu_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        last_lsu_q <= 1'b1;
    else if (grant) last_lsu_q <= pick_lsu;
  end
`else
  always_comb pick_lsu = lsu_req_i;
`endif

  // Gating with rst keeps every output at 0 while reset is held, even with
  // requests present on the inputs.
  assign grant     = (state_q == S_IDLE) && (ifu_req_i || lsu_req_i) && !rst;
  assign ifu_gnt_o = grant && !pick_lsu;
  assign lsu_gnt_o = grant &&  pick_lsu;

  // ---- completion and watchdog ----
  // Completion wins over a timeout landing in the same cycle.
  assign done   = (state_q == S_RESP) && mem_rvalid_i;
  assign wd_hit = WD_EN && (state_q != S_IDLE) && !done &&
                  (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  assign ifu_rvalid_o = (done || wd_hit) && !owner_lsu_q;
  assign lsu_rvalid_o = (done || wd_hit) &&  owner_lsu_q;
  assign ifu_err_o    = wd_hit && !owner_lsu_q;
  assign lsu_err_o    = wd_hit &&  owner_lsu_q;
  assign ifu_rdata_o  = (done && !owner_lsu_q) ? mem_rdata_i : '0;
  assign lsu_rdata_o  = (done &&  owner_lsu_q) ? mem_rdata_i : '0;

  // ---- FSM next state ----
  always_comb begin
    state_d     = state_q;
    owner_lsu_d = owner_lsu_q;
    case (state_q)
      S_IDLE: begin
        if (grant) begin
          state_d     = S_REQ;
          owner_lsu_d = pick_lsu;
        end
      end
      S_REQ: begin
        if (wd_hit)         state_d = S_IDLE;
        else if (mem_gnt_i) state_d = S_RESP;
      end
      S_RESP: begin
        if (done || wd_hit) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---- state, watchdog counter, registered memory request ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_lsu_q <= 1'b0;
      wd_cnt_q    <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_be_o    <= '0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      state_q     <= state_d;
      owner_lsu_q <= owner_lsu_d;
      mem_req_o   <= (state_d == S_REQ);
      if (grant)
        wd_cnt_q <= '0;
      else if (state_q != S_IDLE)
        wd_cnt_q <= wd_cnt_q + 1'b1;
      if (grant) begin
        if (pick_lsu) begin
          mem_we_o    <= lsu_we_i;
          mem_be_o    <= lsu_be_i;
          mem_addr_o  <= lsu_addr_i;
          mem_wdata_o <= lsu_wdata_i;
        end else begin
          mem_we_o    <= 1'b0;
          mem_be_o    <= {BE_W{1'b1}};
          mem_addr_o  <= ifu_addr_i;
          mem_wdata_o <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cotm32_mem_arbiter.sv
module tb_cotm32_mem_arbiter;
  localparam int XLEN = 32;
`ifdef COTM32_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic ifu_req_i, lsu_req_i, lsu_we_i, mem_gnt_i, mem_rvalid_i;
  logic [XLEN-1:0] ifu_addr_i, lsu_addr_i, lsu_wdata_i, mem_rdata_i;
  logic [3:0] lsu_be_i;

  logic ifu_gnt_o, ifu_rvalid_o, ifu_err_o, lsu_gnt_o, lsu_rvalid_o, lsu_err_o;
  logic [XLEN-1:0] ifu_rdata_o, lsu_rdata_o, mem_addr_o, mem_wdata_o;
  logic mem_req_o, mem_we_o;
  logic [3:0] mem_be_o;

  logic z_ifu_gnt_o, z_ifu_rvalid_o, z_ifu_err_o, z_lsu_gnt_o, z_lsu_rvalid_o, z_lsu_err_o;
  logic [XLEN-1:0] z_ifu_rdata_o, z_lsu_rdata_o, z_mem_addr_o, z_mem_wdata_o;
  logic z_mem_req_o, z_mem_we_o;
  logic [3:0] z_mem_be_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cotm32_mem_arbiter #(.XLEN(XLEN), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_i(ifu_req_i), .ifu_addr_i(ifu_addr_i), .ifu_gnt_o(ifu_gnt_o),
    .ifu_rvalid_o(ifu_rvalid_o), .ifu_rdata_o(ifu_rdata_o), .ifu_err_o(ifu_err_o),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_be_i(lsu_be_i),
    .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_gnt_o(lsu_gnt_o),
    .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o), .lsu_err_o(lsu_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  // Watchdog-disabled instance sharing all inputs.
  cotm32_mem_arbiter #(.XLEN(XLEN), .TIMEOUT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst),
    .ifu_req_i(ifu_req_i), .ifu_addr_i(ifu_addr_i), .ifu_gnt_o(z_ifu_gnt_o),
    .ifu_rvalid_o(z_ifu_rvalid_o), .ifu_rdata_o(z_ifu_rdata_o), .ifu_err_o(z_ifu_err_o),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_be_i(lsu_be_i),
    .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_gnt_o(z_lsu_gnt_o),
    .lsu_rvalid_o(z_lsu_rvalid_o), .lsu_rdata_o(z_lsu_rdata_o), .lsu_err_o(z_lsu_err_o),
    .mem_req_o(z_mem_req_o), .mem_we_o(z_mem_we_o), .mem_be_o(z_mem_be_o),
    .mem_addr_o(z_mem_addr_o), .mem_wdata_o(z_mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  logic [139:0] all_out;
  assign all_out = {ifu_gnt_o, ifu_rvalid_o, ifu_rdata_o, ifu_err_o,
                    lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o, lsu_err_o,
                    mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o};

  task automatic idle_in();
    ifu_req_i = 0; ifu_addr_i = '0;
    lsu_req_i = 0; lsu_we_i = 0; lsu_be_i = '0; lsu_addr_i = '0; lsu_wdata_i = '0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    tick(); rst = 1; idle_in();
    tick(); tick();
    rst = 0;
  endtask

  task automatic test_reset();
    tick(); rst = 1; idle_in();
    ifu_req_i = 1; lsu_req_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'hFFFF_FFFF;
    samp();
    total++;
    if (all_out !== '0) begin
      bad++; $display("FAIL reset_outputs: got %h want 0", all_out);
    end
    tick(); idle_in(); rst = 0;
    samp();
    total++;
    if (all_out !== '0) begin
      bad++; $display("FAIL reset_release: got %h want 0", all_out);
    end
  endtask

  task automatic test_ifu_fetch();
    do_reset();
    tick(); ifu_req_i = 1; ifu_addr_i = 32'h100;
    samp();
    total++;
    if ({lsu_gnt_o, ifu_gnt_o, mem_req_o} !== 3'b010) begin
      bad++; $display("FAIL fetch_c0: lsu_gnt,ifu_gnt,mem_req=%b want 010", {lsu_gnt_o, ifu_gnt_o, mem_req_o});
    end
    tick(); idle_in(); mem_gnt_i = 1;
    samp();
    total++;
    if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o} !== {1'b1, 1'b0, 4'hF, 32'h100}) begin
      bad++; $display("FAIL fetch_c1: req=%b we=%b be=%h addr=%h want 1 0 f 100", mem_req_o, mem_we_o, mem_be_o, mem_addr_o);
    end
    tick(); idle_in(); mem_rvalid_i = 1; mem_rdata_i = 32'h13;
    samp();
    total++;
    if ({ifu_rvalid_o, ifu_err_o, ifu_rdata_o, mem_req_o} !== {1'b1, 1'b0, 32'h13, 1'b0}) begin
      bad++; $display("FAIL fetch_c2: rvalid=%b err=%b rdata=%h mem_req=%b want 1 0 13 0", ifu_rvalid_o, ifu_err_o, ifu_rdata_o, mem_req_o);
    end
    tick(); idle_in(); mem_rdata_i = 32'h55;
    samp();
    total++;
    if ({ifu_rvalid_o, ifu_rdata_o} !== 33'h0) begin
      bad++; $display("FAIL fetch_c3: rvalid=%b rdata=%h want 0 0", ifu_rvalid_o, ifu_rdata_o);
    end
  endtask

  task automatic test_lsu_store();
    do_reset();
    tick(); lsu_req_i = 1; lsu_we_i = 1; lsu_be_i = 4'b0011;
    lsu_addr_i = 32'h2000; lsu_wdata_i = 32'hDEADBEEF;
    samp();
    total++;
    if ({lsu_gnt_o, ifu_gnt_o} !== 2'b10) begin
      bad++; $display("FAIL store_gnt: got %b want 10", {lsu_gnt_o, ifu_gnt_o});
    end
    for (int c = 1; c <= 4; c++) begin
      tick(); idle_in(); mem_gnt_i = (c == 4);
      samp();
      total++;
      if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !==
          {1'b1, 1'b1, 4'b0011, 32'h2000, 32'hDEADBEEF} || lsu_rvalid_o !== 1'b0) begin
        bad++; $display("FAIL store_req_c%0d: req=%b we=%b be=%b addr=%h wdata=%h rv=%b want 1 1 0011 2000 deadbeef 0",
                        c, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, lsu_rvalid_o);
      end
    end
    tick(); idle_in(); mem_rvalid_i = 1;
    samp();
    total++;
    if ({lsu_rvalid_o, lsu_err_o, ifu_rvalid_o, mem_req_o} !== 4'b1000) begin
      bad++; $display("FAIL store_resp: lsu_rv,err,ifu_rv,mem_req=%b want 1000", {lsu_rvalid_o, lsu_err_o, ifu_rvalid_o, mem_req_o});
    end
  endtask

  task automatic test_contention();
    logic [1:0] first;
    logic [1:0] second;
    first  = RR ? 2'b01 : 2'b10;   // {lsu, ifu}
    second = ~first;
    do_reset();
    tick(); ifu_req_i = 1; ifu_addr_i = 32'h40; lsu_req_i = 1; lsu_addr_i = 32'h80;
    samp();
    total++;
    if ({lsu_gnt_o, ifu_gnt_o} !== first) begin
      bad++; $display("FAIL tie_first: gnt=%b want %b", {lsu_gnt_o, ifu_gnt_o}, first);
    end
    tick(); ifu_req_i = second[0]; lsu_req_i = second[1]; mem_gnt_i = 1;
    samp();
    total++;
    if ({lsu_gnt_o, ifu_gnt_o} !== 2'b00) begin
      bad++; $display("FAIL tie_busy: gnt=%b want 00", {lsu_gnt_o, ifu_gnt_o});
    end
    tick(); mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hA5A5;
    samp();
    total++;
    if ({lsu_rvalid_o, ifu_rvalid_o, lsu_gnt_o, ifu_gnt_o} !== {first, 2'b00}) begin
      bad++; $display("FAIL tie_resp: rv,gnt=%b want %b", {lsu_rvalid_o, ifu_rvalid_o, lsu_gnt_o, ifu_gnt_o}, {first, 2'b00});
    end
    tick(); mem_rvalid_i = 0;
    samp();
    total++;
    if ({lsu_gnt_o, ifu_gnt_o} !== second) begin
      bad++; $display("FAIL tie_second: gnt=%b want %b", {lsu_gnt_o, ifu_gnt_o}, second);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    tick(); lsu_req_i = 1; lsu_addr_i = 32'h3000;
    samp();
    total++;
    if (lsu_gnt_o !== 1'b1) begin
      bad++; $display("FAIL to_gnt: got %b want 1", lsu_gnt_o);
    end
    tick(); idle_in(); mem_gnt_i = 1;
    for (int c = 2; c <= 15; c++) begin
      tick(); idle_in(); mem_rdata_i = 32'h1234_5678;
      samp();
      total++;
      if ({lsu_rvalid_o, lsu_err_o} !== 2'b00) begin
        bad++; $display("FAIL to_wait_c%0d: rv,err=%b want 00", c, {lsu_rvalid_o, lsu_err_o});
      end
    end
    tick();
    samp();
    total++;
    if ({lsu_rvalid_o, lsu_err_o, lsu_rdata_o, ifu_rvalid_o} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
      bad++; $display("FAIL to_fire: rv=%b err=%b rdata=%h ifu_rv=%b want 1 1 0 0", lsu_rvalid_o, lsu_err_o, lsu_rdata_o, ifu_rvalid_o);
    end
    for (int c = 17; c <= 18; c++) begin
      tick(); mem_rvalid_i = 1;
      samp();
      total++;
      if ({lsu_rvalid_o, ifu_rvalid_o, mem_req_o} !== 3'b000) begin
        bad++; $display("FAIL to_stray_c%0d: lsu_rv,ifu_rv,mem_req=%b want 000", c, {lsu_rvalid_o, ifu_rvalid_o, mem_req_o});
      end
    end
    tick(); idle_in(); ifu_req_i = 1; ifu_addr_i = 32'h44;
    samp();
    total++;
    if (ifu_gnt_o !== 1'b1) begin
      bad++; $display("FAIL to_idle_gnt: got %b want 1", ifu_gnt_o);
    end
  endtask

  task automatic test_reset_in_resp();
    do_reset();
    tick(); ifu_req_i = 1; ifu_addr_i = 32'h500;
    tick(); idle_in(); mem_gnt_i = 1;
    tick(); idle_in(); rst = 1; mem_rvalid_i = 1; mem_rdata_i = 32'hCAFE;
    samp();
    total++;
    if (all_out !== '0) begin
      bad++; $display("FAIL rst_resp: got %h want 0", all_out);
    end
    tick(); rst = 0;
    samp();
    total++;
    if ({ifu_rvalid_o, lsu_rvalid_o, mem_req_o} !== 3'b000) begin
      bad++; $display("FAIL rst_late_rv: rv,rv,req=%b want 000", {ifu_rvalid_o, lsu_rvalid_o, mem_req_o});
    end
    tick(); idle_in(); ifu_req_i = 1; ifu_addr_i = 32'h600;
    samp();
    total++;
    if (ifu_gnt_o !== 1'b1) begin
      bad++; $display("FAIL rst_regrant: got %b want 1", ifu_gnt_o);
    end
    tick(); idle_in(); mem_gnt_i = 1;
    samp();
    total++;
    if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h600}) begin
      bad++; $display("FAIL rst_req: req=%b addr=%h want 1 600", mem_req_o, mem_addr_o);
    end
    tick(); idle_in(); mem_rvalid_i = 1; mem_rdata_i = 32'h77;
    samp();
    total++;
    if ({ifu_rvalid_o, ifu_rdata_o} !== {1'b1, 32'h77}) begin
      bad++; $display("FAIL rst_resp2: rv=%b rdata=%h want 1 77", ifu_rvalid_o, ifu_rdata_o);
    end
  endtask

  task automatic test_no_watchdog();
    int early;
    early = 0;
    do_reset();
    tick(); ifu_req_i = 1; ifu_addr_i = 32'h900;
    samp();
    total++;
    if (z_ifu_gnt_o !== 1'b1) begin
      bad++; $display("FAIL nowd_gnt: got %b want 1", z_ifu_gnt_o);
    end
    tick(); idle_in(); mem_gnt_i = 1;
    for (int c = 2; c <= 99; c++) begin
      tick(); idle_in();
      samp();
      if (z_ifu_rvalid_o !== 1'b0 || z_ifu_err_o !== 1'b0) early++;
    end
    total++;
    if (early != 0) begin
      bad++; $display("FAIL nowd_stall: early responses=%0d want 0", early);
    end
    tick(); mem_rvalid_i = 1; mem_rdata_i = 32'hBEEF_0100;
    samp();
    total++;
    if ({z_ifu_rvalid_o, z_ifu_err_o, z_ifu_rdata_o} !== {1'b1, 1'b0, 32'hBEEF_0100}) begin
      bad++; $display("FAIL nowd_resp: rv=%b err=%b rdata=%h want 1 0 beef0100", z_ifu_rvalid_o, z_ifu_err_o, z_ifu_rdata_o);
    end
  endtask

  // Transaction-level reference: a bus is either free, waiting for memory
  // acceptance, or waiting for data; a free bus grants any requester.
  task automatic test_random();
    int phase, wait_cnt;
    bit pend_i, pend_l, own_lsu, last_lsu, lsu_win, rv;
    logic [1:0] exp_gnt;
    logic [XLEN-1:0] i_addr, l_addr, l_wdata, e_addr, e_wdata;
    logic l_we, e_we;
    logic [3:0] l_be, e_be;
    phase = 0; wait_cnt = 0; pend_i = 0; pend_l = 0; own_lsu = 0; last_lsu = 1;
    i_addr = '0; l_addr = '0; l_wdata = '0; l_we = 0; l_be = '0;
    e_addr = '0; e_wdata = '0; e_we = 0; e_be = '0;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      tick();
      if (!pend_i && $urandom_range(0, 2) == 0) begin pend_i = 1; i_addr = $urandom; end
      if (!pend_l && $urandom_range(0, 2) == 0) begin
        pend_l = 1; l_addr = $urandom; l_wdata = $urandom;
        l_we = 1'($urandom_range(0, 1)); l_be = 4'($urandom_range(0, 15));
      end
      ifu_req_i = pend_i; ifu_addr_i = i_addr;
      lsu_req_i = pend_l; lsu_addr_i = l_addr; lsu_wdata_i = l_wdata;
      lsu_we_i = l_we; lsu_be_i = l_be;
      mem_gnt_i    = (phase == 1) && (wait_cnt >= 3 || $urandom_range(0, 1) == 1);
      mem_rvalid_i = (phase == 2) ? (wait_cnt >= 3 || $urandom_range(0, 1) == 1)
                                  : ($urandom_range(0, 9) == 0);
      mem_rdata_i  = $urandom;
      samp();
      lsu_win = pend_l && (!pend_i || !RR || !last_lsu);
      exp_gnt = (phase == 0 && (pend_i || pend_l)) ? (lsu_win ? 2'b10 : 2'b01) : 2'b00;
      rv = (phase == 2) && mem_rvalid_i;
      total++;
      if ({lsu_gnt_o, ifu_gnt_o} !== exp_gnt) begin
        bad++; $display("FAIL rnd_gnt n=%0d: got %b want %b", n, {lsu_gnt_o, ifu_gnt_o}, exp_gnt);
      end
      total++;
      if (mem_req_o !== (phase == 1)) begin
        bad++; $display("FAIL rnd_mem_req n=%0d: got %b want %b", n, mem_req_o, phase == 1);
      end
      if (phase == 1) begin
        total++;
        if ({mem_we_o, mem_be_o, mem_addr_o} !== {e_we, e_be, e_addr} ||
            (own_lsu && mem_wdata_o !== e_wdata)) begin
          bad++; $display("FAIL rnd_payload n=%0d: we=%b be=%h addr=%h wd=%h want %b %h %h %h",
                          n, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, e_we, e_be, e_addr, e_wdata);
        end
      end
      total++;
      if ({lsu_rvalid_o, ifu_rvalid_o, lsu_err_o, ifu_err_o, lsu_rdata_o, ifu_rdata_o} !==
          {rv && own_lsu, rv && !own_lsu, 2'b00,
           (rv && own_lsu) ? mem_rdata_i : 32'h0, (rv && !own_lsu) ? mem_rdata_i : 32'h0}) begin
        bad++; $display("FAIL rnd_resp n=%0d: rv=%b%b err=%b%b rdata=%h/%h want rv=%b%b own_lsu=%b data=%h",
                        n, lsu_rvalid_o, ifu_rvalid_o, lsu_err_o, ifu_err_o, lsu_rdata_o, ifu_rdata_o,
                        rv && own_lsu, rv && !own_lsu, own_lsu, mem_rdata_i);
      end
      wait_cnt++;
      if (phase == 1 && mem_gnt_i) begin phase = 2; wait_cnt = 0; end
      else if (rv) phase = 0;
      if (exp_gnt != 2'b00) begin
        phase = 1; wait_cnt = 0; own_lsu = lsu_win; last_lsu = lsu_win;
        if (lsu_win) begin
          e_we = l_we; e_be = l_be; e_addr = l_addr; e_wdata = l_wdata; pend_l = 0;
        end else begin
          e_we = 0; e_be = 4'hF; e_addr = i_addr; e_wdata = '0; pend_i = 0;
        end
      end
    end
  endtask

  initial begin
    rst = 1; idle_in();
    test_reset();
    test_ifu_fetch();
    test_lsu_store();
    test_contention();
    test_timeout();
    test_reset_in_resp();
    test_no_watchdog();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
